id_ex_imm_stage: RTL and testbench
==================================

Name: id_ex_imm_stage

Overview:
- Pipeline stage directly downstream of the immediate extender, at the ID→EX boundary.
- Consumes the four extended-immediate buses plus rt data and PC+4, and selects the EX operand B.
- Precomputes the branch target (PC+4 + SignExt18) and registers the results behind a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so EX back-pressure never forms a combinational path into ID.

Parameters:
- DATA_W, 32, width of operand, PC and extended-immediate buses.
- SEL_W, 3, width of imm_sel.

Ports:
- clk  in  1  Pipeline clock, rising edge.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  ID holds a valid instruction's operands.
- in_ready  out  1  Stage can accept; registered.
- imm_sel  in  SEL_W  Operand B source: 0 RT, 1 ZEXT5, 2 ZEXT16, 3 SEXT16, 4 LUI, 5–7 illegal.
- imm16  in  16  Raw immediate (used for LUI).
- zero_ext5  in  DATA_W  Zero-extended shamt.
- zero_ext16  in  DATA_W  Zero-extended imm16.
- sign_ext16  in  DATA_W  Sign-extended imm16.
- sign_ext18  in  DATA_W  Sign-extended imm16 shifted left 2.
- rt_data  in  DATA_W  Register-file rt read data.
- pc_plus4  in  DATA_W  PC of instruction + 4.
- flush  in  1  Squash all held and incoming entries.
- out_valid  out  1  op_b / branch_target valid to EX.
- out_ready  in  1  EX accepts this cycle.
- op_b  out  DATA_W  Selected operand B.
- branch_target  out  DATA_W  pc_plus4 + sign_ext18, modulo 2^DATA_W.
- illegal_sel  out  1  Registered flag for an illegal imm_sel (see Optional Feature).

Behaviour:
- Reset: all outputs and internal registers go to 0 at the next clock edge. out_valid=0, in_ready=0 during reset; in_ready=1 the cycle after rst deasserts.
- Operand select (combinational, before registering):
  - RT→rt_data; ZEXT5→zero_ext5; ZEXT16→zero_ext16; SEXT16→sign_ext16; LUI→{imm16,16'h0}.
  - Illegal codes→0.
- branch_target: pc_plus4 + sign_ext18, carry discarded, computed for every entry regardless of sel.
- Transfer rules:
  - Accept when in_valid & in_ready.
  - Deliver when out_valid & out_ready.
- Storage: main register M (drives outputs) plus skid register S.
- States by (M.valid, S.valid):
  - EMPTY(0,0): accept→M; goto ONE.
  - ONE(1,0):
    - deliver & accept: M←input, stay ONE.
    - deliver only: goto EMPTY.
    - accept only: S←input, goto FULL.
    - neither: hold.
  - FULL(1,1): in_ready=0.
    - deliver: M←S; goto ONE.
    - otherwise hold.
- in_ready is registered and equals !S.valid for the next cycle.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput: 1/cycle when out_ready stays high.
- Output data is stable while out_valid & !out_ready.
- Flush:
  - Clears M.valid and S.valid at the edge; any same-cycle input is dropped (flush beats accept).
  - Data registers need not clear. Next cycle: out_valid=0, in_ready=1.
- rst asserted mid-operation behaves exactly like reset from power-up and also clears data. rst beats flush.

Optional Feature:
- Macro: IMM_SEL_CHECK_EN.
- Defined: an illegal imm_sel on an accepted entry still yields op_b=0. illegal_sel is set and travels with the entry (held in M/S alongside it), asserted while that entry is at the output. Simulation-only assertion fires on accept of an illegal code.
- Undefined: illegal_sel tied to 0, no extra storage; illegal codes still give op_b=0.

Decomposition:
- Package cpu54_imm_pkg:
  - imm_sel encoding constants (IMM_RT, IMM_ZEXT5, IMM_ZEXT16, IMM_SEXT16, IMM_LUI).
  - DATA_W default.
  - Struct/typedef for the stage payload {op_b, branch_target, illegal_sel}.
- One sub-module, imm_skid_buf: a generic 2-entry valid/ready skid buffer over the payload.
- id_ex_imm_stage holds the select mux and adder, then instantiates imm_skid_buf.

Test Plan:
1. Reset: rst high 2 cycles then low → out_valid=0, op_b=0, illegal_sel=0 during reset; in_ready=1 the next cycle.
2. Select sweep, out_ready=1: imm16=16'h8001 with extender buses driven to match, rt_data=32'hDEADBEEF → next cycle op_b is:
   - sel0: DEADBEEF
   - sel1: shamt value
   - sel2: 00008001
   - sel3: FFFF8001
   - sel4: 80010000
3. Branch target: pc_plus4=32'h0040_0010, sign_ext18=32'hFFFF_FFF8 → branch_target=32'h0040_0008. pc_plus4=FFFF_FFFC, sign_ext18=8 → 0000_0004 (wrap).
4. Back-pressure: out_ready=0, stream A, B, C → A held on op_b, B in skid, in_ready=0 so C is not accepted. Raise out_ready → A, B, C emitted in order, none lost or duplicated.
5. Flush while FULL, with in_valid=1 the same cycle → next cycle out_valid=0, in_ready=1, and the dropped input never appears.
6. Set imm_sel=6 on an accepted entry → op_b=0. illegal_sel=1 with IMM_SEL_CHECK_EN defined, 0 without.

Source files
------------

// File: rtl/cpu54_imm_pkg.sv
// Shared definitions for the ID->EX immediate stage: imm_sel encodings,
// default widths, the registered payload layout and the skid-buffer states.
package cpu54_imm_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_SEL_W  = 3;

    localparam logic [DEF_SEL_W-1:0] IMM_RT     = 3'd0;
    localparam logic [DEF_SEL_W-1:0] IMM_ZEXT5  = 3'd1;
    localparam logic [DEF_SEL_W-1:0] IMM_ZEXT16 = 3'd2;
    localparam logic [DEF_SEL_W-1:0] IMM_SEXT16 = 3'd3;
    localparam logic [DEF_SEL_W-1:0] IMM_LUI    = 3'd4;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] op_b;
        logic [DEF_DATA_W-1:0] branch_target;
        logic                  illegal_sel;
    } stage_payload_t;

    // Encoded so that state == FULL is exactly "skid register occupied".
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register M drives the output,
// skid register S absorbs one entry so in_ready can come straight from a flop.
module imm_skid_buf
    import cpu54_imm_pkg::*;
#(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Handshake: a word moves on any cycle where valid and ready are both high;
    // a producer holds valid and data steady until that happens.
    skid_state_t state, state_n;
    logic [W-1:0] m_data, s_data;
    logic         ready_q, ready_n;
    logic         accept, deliver;
    logic         load_m, load_s, m_from_s;

    assign accept    = in_valid & ready_q;
    assign deliver   = (state != SKID_EMPTY) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = (state != SKID_EMPTY);
    assign out_data  = m_data;

    always_comb begin
        state_n  = state;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        case (state)
            SKID_EMPTY: begin
                if (accept) begin
                    load_m  = 1'b1;
                    state_n = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (deliver && accept) begin
                    load_m = 1'b1;
                end else if (deliver) begin
                    state_n = SKID_EMPTY;
                end else if (accept) begin
                    load_s  = 1'b1;
                    state_n = SKID_FULL;
                end
            end
            SKID_FULL: begin
                if (deliver) begin
                    m_from_s = 1'b1;
                    state_n  = SKID_ONE;
                end
            end
            default: state_n = SKID_EMPTY;
        endcase
        // Flush wins over any same-cycle transfer; stale data may stay behind.
        if (flush) begin
            state_n  = SKID_EMPTY;
            load_m   = 1'b0;
            load_s   = 1'b0;
            m_from_s = 1'b0;
        end
        ready_n = (state_n != SKID_FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SKID_EMPTY;
            ready_q <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else begin
            state   <= state_n;
            ready_q <= ready_n;
            if (load_m) begin
                m_data <= in_data;
            end else if (m_from_s) begin
                m_data <= s_data;
            end
            if (load_s) begin
                s_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_imm_stage.sv
// ID->EX stage: selects operand B, precomputes the branch target and registers
// both behind a skid buffer. Define IMM_SEL_CHECK_EN to carry an illegal-select flag.
module id_ex_imm_stage
    import cpu54_imm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  imm_sel,
    input  logic [15:0]       imm16,
    input  logic [DATA_W-1:0] zero_ext5,
    input  logic [DATA_W-1:0] zero_ext16,
    input  logic [DATA_W-1:0] sign_ext16,
    input  logic [DATA_W-1:0] sign_ext18,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] branch_target,
    output logic              illegal_sel
);

    logic [DATA_W-1:0] op_b_sel;
    logic [DATA_W-1:0] target_sum;

    always_comb begin
        op_b_sel = '0;
        case (imm_sel)
            IMM_RT:     op_b_sel = rt_data;
            IMM_ZEXT5:  op_b_sel = zero_ext5;
            IMM_ZEXT16: op_b_sel = zero_ext16;
            IMM_SEXT16: op_b_sel = sign_ext16;
            IMM_LUI:    op_b_sel = {imm16, 16'h0000};
            default:    op_b_sel = '0;
        endcase
    end

    // Carry out is dropped: the target wraps modulo 2^DATA_W.
    assign target_sum = pc_plus4 + sign_ext18;

`ifdef IMM_SEL_CHECK_EN
    localparam int PAY_W = $bits(stage_payload_t);

    logic           sel_illegal;
    stage_payload_t pay_in, pay_out;
    logic [PAY_W-1:0] skid_out;

    assign sel_illegal = (imm_sel > IMM_LUI);
    assign pay_in      = '{op_b: op_b_sel, branch_target: target_sum, illegal_sel: sel_illegal};
    assign pay_out     = skid_out;

    imm_skid_buf #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

    assign op_b          = pay_out.op_b;
    assign branch_target = pay_out.branch_target;
    assign illegal_sel   = pay_out.illegal_sel;

    sel_legal_on_accept: assert property (@(posedge clk) disable iff (rst)
        (in_valid && in_ready) |-> !sel_illegal);
`else
    logic [2*DATA_W-1:0] skid_out;

    imm_skid_buf #(.W(2*DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({op_b_sel, target_sum}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

    assign op_b          = skid_out[2*DATA_W-1:DATA_W];
    assign branch_target = skid_out[DATA_W-1:0];
    assign illegal_sel   = 1'b0;
`endif

endmodule

// File: tb/tb_id_ex_imm_stage.sv
// Directed bench for id_ex_imm_stage: operand select, branch target wrap,
// back-pressure ordering, flush, illegal select and mid-run reset.
module tb_id_ex_imm_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_sel;
    logic [15:0] imm16;
    logic [31:0] zero_ext5, zero_ext16, sign_ext16, sign_ext18;
    logic [31:0] rt_data, pc_plus4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op_b, branch_target;
    logic        illegal_sel;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    bit          sb_en = 1'b0;

    id_ex_imm_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .imm_sel       (imm_sel),
        .imm16         (imm16),
        .zero_ext5     (zero_ext5),
        .zero_ext16    (zero_ext16),
        .sign_ext16    (sign_ext16),
        .sign_ext18    (sign_ext18),
        .rt_data       (rt_data),
        .pc_plus4      (pc_plus4),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op_b          (op_b),
        .branch_target (branch_target),
        .illegal_sel   (illegal_sel)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one instruction's operands; extender buses follow imm16,
    // sign_ext18 is given explicitly so target cases can be chosen freely.
    task automatic drive(input logic v, input logic [2:0] sel, input logic [15:0] imm,
                         input logic [31:0] rt, input logic [31:0] pc, input logic [31:0] se18);
        in_valid   = v;
        imm_sel    = sel;
        imm16      = imm;
        zero_ext5  = {27'b0, imm[10:6]};
        zero_ext16 = {16'h0000, imm};
        sign_ext16 = {{16{imm[15]}}, imm};
        rt_data    = rt;
        pc_plus4   = pc;
        sign_ext18 = se18;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every delivered op_b must match the oldest expected entry.
    always @(negedge clk) begin
        if (sb_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
            else check("sb_order", op_b, exp_q.pop_front());
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 32'h0, 32'h0, 32'h0);

        // Reset
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_op_b", op_b, 0);
        check("rst_illegal", illegal_sel, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Select sweep with EX always ready
        out_ready = 1'b1;
        drive(1'b1, 3'd0, 16'h8001, 32'hDEADBEEF, 32'h0, 32'h0); tick();
        check("sel_rt", op_b, 32'hDEADBEEF);
        check("sel_rt_valid", out_valid, 1);
        drive(1'b1, 3'd1, 16'h8001, 32'hDEADBEEF, 32'h0, 32'h0); tick();
        check("sel_zext5_a", op_b, 32'h0000_0000);
        drive(1'b1, 3'd1, 16'h0540, 32'hDEADBEEF, 32'h0, 32'h0); tick();
        check("sel_zext5_b", op_b, 32'h0000_0015);
        drive(1'b1, 3'd2, 16'h8001, 32'hDEADBEEF, 32'h0, 32'h0); tick();
        check("sel_zext16", op_b, 32'h0000_8001);
        drive(1'b1, 3'd3, 16'h8001, 32'hDEADBEEF, 32'h0, 32'h0); tick();
        check("sel_sext16", op_b, 32'hFFFF_8001);
        drive(1'b1, 3'd4, 16'h8001, 32'hDEADBEEF, 32'h0, 32'h0); tick();
        check("sel_lui", op_b, 32'h8001_0000);

        // Branch target, including wrap-around
        drive(1'b1, 3'd0, 16'hFFFE, 32'h1, 32'h0040_0010, 32'hFFFF_FFF8); tick();
        check("bt_back", branch_target, 32'h0040_0008);
        drive(1'b1, 3'd0, 16'h0002, 32'h1, 32'hFFFF_FFFC, 32'h0000_0008); tick();
        check("bt_wrap", branch_target, 32'h0000_0004);
        drive(1'b0, 3'd0, 16'h0, 32'h0, 32'h0, 32'h0); tick();
        check("drain_out_valid", out_valid, 0);

        // Back-pressure: A held, B skidded, C refused until space frees
        sb_en = 1'b1;
        exp_q.push_back(32'hAAAA_0001);
        exp_q.push_back(32'hBBBB_0002);
        exp_q.push_back(32'hCCCC_0003);
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0, 32'hAAAA_0001, 32'h0, 32'h0); tick();
        check("bp_a_op_b", op_b, 32'hAAAA_0001);
        check("bp_a_in_ready", in_ready, 1);
        drive(1'b1, 3'd0, 16'h0, 32'hBBBB_0002, 32'h0, 32'h0); tick();
        check("bp_b_hold", op_b, 32'hAAAA_0001);
        check("bp_full_in_ready", in_ready, 0);
        drive(1'b1, 3'd0, 16'h0, 32'hCCCC_0003, 32'h0, 32'h0); tick();
        check("bp_c_hold", op_b, 32'hAAAA_0001);
        check("bp_c_in_ready", in_ready, 0);
        out_ready = 1'b1; tick();
        check("bp_b_out", op_b, 32'hBBBB_0002);
        tick();
        check("bp_c_out", op_b, 32'hCCCC_0003);
        in_valid = 1'b0; tick();
        check("bp_empty", out_valid, 0);
        sb_en = 1'b0;
        check("sb_drain", exp_q.size(), 0);

        // Flush while FULL with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0, 32'hD0D0_0004, 32'h0, 32'h0); tick();
        drive(1'b1, 3'd0, 16'h0, 32'hE0E0_0005, 32'h0, 32'h0); tick();
        check("fl_full_in_ready", in_ready, 0);
        flush = 1'b1;
        drive(1'b1, 3'd0, 16'h0, 32'hF0F0_0006, 32'h0, 32'h0); tick();
        flush = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        in_valid = 1'b0; out_ready = 1'b1; tick();
        check("fl_dropped", out_valid, 0);

        // Flush beats an accept that would otherwise succeed
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0, 32'h1111_0007, 32'h0, 32'h0); tick();
        check("fl1_one_valid", out_valid, 1);
        flush = 1'b1;
        drive(1'b1, 3'd0, 16'h0, 32'h2222_0008, 32'h0, 32'h0); tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl1_out_valid", out_valid, 0);
        check("fl1_in_ready", in_ready, 1);
        tick();
        check("fl1_stays_empty", out_valid, 0);

        // Illegal select yields zero operand
        out_ready = 1'b1;
        drive(1'b1, 3'd6, 16'h8001, 32'hDEADBEEF, 32'h0, 32'h0); tick();
        check("ill_op_b", op_b, 32'h0);
        check("ill_valid", out_valid, 1);
`ifdef IMM_SEL_CHECK_EN
        check("ill_flag", illegal_sel, 1);
`else
        check("ill_flag", illegal_sel, 0);
`endif
        drive(1'b1, 3'd2, 16'h1234, 32'h0, 32'h0, 32'h0); tick();
        check("legal_after_ill", op_b, 32'h0000_1234);
        check("legal_flag", illegal_sel, 0);

        // Reset mid-run while FULL; reset beats flush and clears data
        out_ready = 1'b0;
        drive(1'b1, 3'd0, 16'h0, 32'h3333_0009, 32'h0000_0100, 32'h4); tick();
        rst = 1'b1; flush = 1'b1; tick();
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_op_b", op_b, 0);
        check("mid_rst_bt", branch_target, 0);
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; tick();
        check("mid_rst_ready_back", in_ready, 1);
        check("mid_rst_still_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
